// File: rtl/button_conditioner.sv
// button_conditioner
//
// Input stage for the tic-tac-toe game controller. Each of the five raw board
// push-buttons is synchronised, debounced and turned into a single one-clock
// pulse. An arbiter makes sure at most one pulse is high in any cycle, because
// the game FSM tests its button inputs independently and would act on
// simultaneous pulses in conflicting ways.
//
// Parameters:
//   DB_COUNT  stable cycles needed to qualify a press or a release (>= 2)
//   CNT_W     debounce counter width, 2**CNT_W > DB_COUNT-1
//
// Ports:
//   Clk       system clock
//   Reset     asynchronous, active-high reset
//   BtnL/R/U/D/C  raw asynchronous, bouncy buttons
//   Lbtn/Rbtn/Ubtn/Dbtn/Cbtn  one-cycle pulses, at most one high per cycle
//   BtnLevel  debounced levels {C,L,R,U,D}, 1 = qualified pressed
//
// Internally every per-channel vector is ordered {C,L,R,U,D}, so bit 4 is the
// highest-priority channel and bit 0 the lowest.

module button_conditioner #(
    parameter int unsigned DB_COUNT = 500000,
    parameter int unsigned CNT_W    = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnC,
    output logic       Lbtn,
    output logic       Rbtn,
    output logic       Ubtn,
    output logic       Dbtn,
    output logic       Cbtn,
    output logic [4:0] BtnLevel
);

    localparam int unsigned NumCh = 5;
    localparam int unsigned ChC   = 4;
    localparam int unsigned ChL   = 3;
    localparam int unsigned ChR   = 2;
    localparam int unsigned ChU   = 1;
    localparam int unsigned ChD   = 0;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {
        StIni,   // released
        StWq,    // wait for the press to stay stable
        StCcr,   // qualified pressed
        StWfcr   // wait for the release to stay stable
    } state_e;

    logic [NumCh-1:0] raw;
    logic [NumCh-1:0] sync1_q;
    logic [NumCh-1:0] sync2_q;
    logic [NumCh-1:0] pend_set;
    logic [NumCh-1:0] level;
    logic [NumCh-1:0] pend_q;
    logic [NumCh-1:0] pend_d;
    logic [NumCh-1:0] pulse_q;
    logic [NumCh-1:0] pulse_d;
    logic [NumCh-1:0] grant;

    assign raw = {BtnC, BtnL, BtnR, BtnU, BtnD};

    // Two-flop synchroniser per channel.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce FSM. A press is reported once, on the edge that
    // enters StCcr; bouncing back from StWfcr to StCcr never reports again.
    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             set_d;
        logic             s;

        assign s = sync2_q[i];

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            set_d   = 1'b0;
            case (state_q)
                StIni: begin
                    if (s) begin
                        state_d = StWq;
                        cnt_d   = '0;
                    end
                end
                StWq: begin
                    if (!s) begin
                        state_d = StIni;
                    end else if (cnt_q == CntMax) begin
                        state_d = StCcr;
                        set_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                StCcr: begin
                    if (!s) begin
                        state_d = StWfcr;
                        cnt_d   = '0;
                    end
                end
                StWfcr: begin
                    if (s) begin
                        state_d = StCcr;
                    end else if (cnt_q == CntMax) begin
                        state_d = StIni;
                    end else begin
                        cnt_d = cnt_q + CntOne;
                    end
                end
                default: begin
                    state_d = StIni;
                    cnt_d   = '0;
                end
            endcase
        end

        always_ff @(posedge Clk or posedge Reset) begin
            if (Reset) begin
                state_q <= StIni;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign pend_set[i] = set_d;
        assign level[i]    = (state_q == StCcr) || (state_q == StWfcr);
    end

    // Fixed-priority grant C > L > R > U > D over the pending presses.
    always_comb begin
        grant = '0;
        if (pend_q[ChC]) begin
            grant[ChC] = 1'b1;
        end else if (pend_q[ChL]) begin
            grant[ChL] = 1'b1;
        end else if (pend_q[ChR]) begin
            grant[ChR] = 1'b1;
        end else if (pend_q[ChU]) begin
            grant[ChU] = 1'b1;
        end else if (pend_q[ChD]) begin
            grant[ChD] = 1'b1;
        end
    end

    // A channel cannot set its own pend bit again before it is served (that
    // needs a full release and re-press), so clearing the granted bit and
    // OR-ing in new presses never loses an event.
    always_comb begin
        pend_d  = (pend_q & ~grant) | pend_set;
        pulse_d = grant;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pend_q  <= '0;
            pulse_q <= '0;
        end else begin
            pend_q  <= pend_d;
            pulse_q <= pulse_d;
        end
    end

    assign Cbtn     = pulse_q[ChC];
    assign Lbtn     = pulse_q[ChL];
    assign Rbtn     = pulse_q[ChR];
    assign Ubtn     = pulse_q[ChU];
    assign Dbtn     = pulse_q[ChD];
    assign BtnLevel = level;

endmodule
